dac_filter_loader: RTL and testbench
====================================

// Module: dac_filter_loader
// PURPOSE
//  Sequences FIR coefficient reloads for one DAC channel. Software fills a local coefficient RAM over the APB-style bus,
//  then issues START. The block mutes the channel, drains the pipeline and streams the taps into the filter cfg_din/cfg_ce
//  port. It then waits for the filter to settle and unmutes. It sits beside the channel register block and drives the
//  filter's config port in its place.
// PARAMETERS
//  NUM_TAPS      64   coefficient RAM depth / max filter length
//  COEF_WIDTH    25   coefficient width, matches filter cfg_din
//  DRAIN_CYCLES  16   muted cycles before streaming (flush old samples)
//  SETTLE_CYCLES 64   muted cycles after last tap (new taps fill delay line)
// PORTS
//  clk       in   1   channel clock
//  reset     in   1   asynchronous, active-high reset
//  penable   in   1   bus enable phase
//  psel      in   1   block select
//  paddr     in   32  byte address, paddr[7:0] decoded
//  pwrite    in   1   1=write
//  pwdata    in   32  write data
//  prdata    out  32  read data, combinational from paddr
//  cfg_din   out  COEF_WIDTH  coefficient to filter
//  cfg_ce    out  1   one-cycle strobe per coefficient
//  mute      out  1   1 = channel forces DAC output to offset-only
//  busy      out  1   reload in progress
//  done      out  1   one-cycle pulse when reload completes
// BEHAVIOUR
//  Reset: cfg_din=0, cfg_ce=0, mute=0, busy=0, done=0, LEN=NUM_TAPS, COEF_ADDR=0, STATUS=0, FSM=IDLE. RAM contents undefined.
//  Bus write = psel&penable&pwrite, one cycle. Reads have no side effects.
//  Regs: 0x00 CTRL W: b0 START, b1 ABORT (self-clearing). 0x04 STATUS R: b0 busy, b1 done_sticky, b2 err_sticky; write 1 clears b1/b2.
//    0x08 LEN RW (1..NUM_TAPS). 0x0C COEF_ADDR RW. 0x10 COEF_DATA W: RAM[COEF_ADDR]<=pwdata[COEF_WIDTH-1:0], COEF_ADDR++ (wraps to 0 after NUM_TAPS-1).
//  FSM: IDLE -START-> DRAIN (DRAIN_CYCLES) -> STREAM (LEN cycles) -> SETTLE (SETTLE_CYCLES) -> IDLE.
//  mute=1 and busy=1 from the first DRAIN cycle through the last SETTLE cycle inclusive.
//  STREAM: RAM read latency 1. Taps are issued in order LEN-1 down to 0. cfg_ce is high for exactly LEN consecutive cycles,
//    with cfg_din valid in the same cycle. The first cfg_ce occurs DRAIN_CYCLES+1 cycles after the START write.
//  done pulses, and done_sticky sets, in the cycle after SETTLE ends, alongside mute/busy falling.
//  START with LEN==0 or LEN>NUM_TAPS: no load, err_sticky=1.
//  START while busy: ignored, err_sticky=1.
//  COEF_DATA or LEN write while busy: ignored, err_sticky=1.
//  ABORT in any non-IDLE state: FSM goes to IDLE next cycle; cfg_ce=0, mute=0, busy=0, err_sticky=1, no done.
//    The filter may hold partial taps.
//  START and ABORT in the same write: ABORT wins.
//  Reset mid-reload: immediate return to reset values; mute drops asynchronously.
// CONFIGURATION
//  `DAC_FILTER_LOADER_CHECKSUM_EN defined: 0x14 CHECKSUM R returns the 32-bit wrapping sum of the sign-extended cfg_din
//    over all cfg_ce cycles of the last reload. It is cleared on START and holds after done/abort.
//  Not defined: 0x14 reads 0, no adder logic.
// STRUCTURE
//  dac_ctrl_pkg: loader_state_t enum {IDLE,DRAIN,STREAM,SETTLE}, register offset localparams, STATUS bit indices.
//  Sub-module coef_ram: simple dual-port, NUM_TAPS x COEF_WIDTH, sync write, registered read (1 cycle).
//  One shared down-counter serves DRAIN, STREAM and SETTLE; it is loaded on each state entry.
//  Unmapped read addresses return 0.
// TESTING
//  Write 8 taps 1..8 at addr 0, LEN=8, START -> cfg_ce high 8 cycles, cfg_din=8,7,...,1, first ce at cycle 17, done at cycle 16+8+64+1.
//  LEN=0 then START -> no cfg_ce, busy stays 0, STATUS=0x4; write 0x4 to STATUS -> STATUS=0.
//  START, then ABORT in the 3rd STREAM cycle -> exactly 2 cfg_ce seen, mute/busy 0 next cycle, STATUS b2=1, b1=0.
//  COEF_DATA write during SETTLE -> RAM unchanged (reload again, same taps emitted), err_sticky=1.
//  COEF_ADDR=NUM_TAPS-1, write two words -> second lands at addr 0, COEF_ADDR reads 1.
//  Assert reset during STREAM -> mute/cfg_ce/busy 0 same cycle. CHECKSUM_EN build with taps -1,2,3 -> CHECKSUM=4.

Source files
------------

// File: rtl/dac_ctrl_pkg.sv
// Shared types and register map for the DAC filter coefficient loader.
package dac_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        STREAM = 2'd2,
        SETTLE = 2'd3
    } loader_state_t;

    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_LEN       = 8'h08;
    localparam logic [7:0] REG_COEF_ADDR = 8'h0C;
    localparam logic [7:0] REG_COEF_DATA = 8'h10;
    localparam logic [7:0] REG_CHECKSUM  = 8'h14;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dac_filter_loader_coef_ram.sv
// Coefficient store: simple dual-port RAM, synchronous write, one-cycle registered read.
module coef_ram
    import dac_ctrl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 25,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dac_filter_loader.sv
// Mutes a DAC channel, drains it, streams RAM taps into the FIR config port, settles, unmutes.
// Optional DAC_FILTER_LOADER_CHECKSUM_EN adds a readable sum of the streamed taps at 0x14.
module dac_filter_loader
    import dac_ctrl_pkg::*;
#(
    parameter int NUM_TAPS      = 64,
    parameter int COEF_WIDTH    = 25,
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  penable,
    input  logic                  psel,
    input  logic [31:0]           paddr,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic [COEF_WIDTH-1:0] cfg_din,
    output logic                  cfg_ce,
    output logic                  mute,
    output logic                  busy,
    output logic                  done
);

    localparam int AW    = $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(max3(NUM_TAPS, DRAIN_CYCLES, SETTLE_CYCLES) + 1);

    loader_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            len_q;
    logic [AW-1:0]          coef_addr_q;
    logic                   done_q, done_sticky_q, err_sticky_q;
    logic [COEF_WIDTH-1:0]  ram_rdata;
    logic [AW-1:0]          ram_raddr;
    logic [31:0]            checksum_rd;

    logic [7:0] reg_addr;
    logic bus_wr, ctrl_wr, status_wr, len_wr, addr_wr, data_wr;
    logic start_req, abort_req, idle, len_ok, load_go, last_cnt, reload_done, ram_we, err_set;
    logic unused_paddr;

    assign reg_addr  = paddr[7:0];
    assign bus_wr    = psel & penable & pwrite;
    assign ctrl_wr   = bus_wr && (reg_addr == REG_CTRL);
    assign status_wr = bus_wr && (reg_addr == REG_STATUS);
    assign len_wr    = bus_wr && (reg_addr == REG_LEN);
    assign addr_wr   = bus_wr && (reg_addr == REG_COEF_ADDR);
    assign data_wr   = bus_wr && (reg_addr == REG_COEF_DATA);

    // ABORT takes precedence when both control bits are written together.
    assign abort_req   = ctrl_wr & pwdata[CTRL_ABORT_BIT];
    assign start_req   = ctrl_wr & pwdata[CTRL_START_BIT] & ~pwdata[CTRL_ABORT_BIT];
    assign idle        = (state_q == IDLE);
    assign len_ok      = (len_q != 32'd0) && (len_q <= 32'(NUM_TAPS));
    assign load_go     = start_req & idle & len_ok;
    assign last_cnt    = (cnt_q == CNT_W'(1));
    assign reload_done = (state_q == SETTLE) && last_cnt && !abort_req;
    assign ram_we      = data_wr & idle;
    assign err_set     = (start_req & (!idle | !len_ok))
                       | ((data_wr | len_wr) & !idle)
                       | (abort_req & !idle);
    assign unused_paddr = ^paddr[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One down-counter is reloaded on every state entry and times all three phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (load_go) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: if (last_cnt) begin
                state_d = STREAM;
                cnt_d   = CNT_W'(len_q);
            end
            STREAM: if (last_cnt) begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYCLES);
            end
            SETTLE: if (last_cnt) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_req && !idle) begin
            state_d = IDLE;
        end
    end

    // Read address runs one tap ahead of cfg_ce to absorb the RAM read latency.
    always_comb begin
        busy      = !idle;
        mute      = !idle;
        cfg_ce    = (state_q == STREAM) && !abort_req;
        ram_raddr = AW'(len_q - 32'd1);
        if (state_q == STREAM) begin
            ram_raddr = AW'(cnt_q - CNT_W'(2));
        end
    end

    assign cfg_din = cfg_ce ? ram_rdata : '0;
    assign done    = done_q;

    coef_ram #(
        .DEPTH (NUM_TAPS),
        .WIDTH (COEF_WIDTH)
    ) u_coef_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (coef_addr_q),
        .wdata_i (pwdata[COEF_WIDTH-1:0]),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q         <= 32'(NUM_TAPS);
            coef_addr_q   <= '0;
            done_q        <= 1'b0;
            done_sticky_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            done_q <= reload_done;
            if (len_wr && idle) begin
                len_q <= pwdata;
            end
            if (addr_wr) begin
                coef_addr_q <= pwdata[AW-1:0];
            end else if (ram_we) begin
                coef_addr_q <= (coef_addr_q == AW'(NUM_TAPS - 1)) ? '0 : coef_addr_q + AW'(1);
            end
            if (reload_done) begin
                done_sticky_q <= 1'b1;
            end else if (status_wr && pwdata[STATUS_DONE_BIT]) begin
                done_sticky_q <= 1'b0;
            end
            if (err_set) begin
                err_sticky_q <= 1'b1;
            end else if (status_wr && pwdata[STATUS_ERR_BIT]) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

`ifdef DAC_FILTER_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (load_go) begin
            checksum_q <= '0;
        end else if (cfg_ce) begin
            checksum_q <= checksum_q + 32'($signed(cfg_din));
        end
    end

    assign checksum_rd = checksum_q;
`else
    assign checksum_rd = '0;
`endif

    always_comb begin
        prdata = '0;
        case (reg_addr)
            REG_STATUS: begin
                prdata[STATUS_BUSY_BIT] = !idle;
                prdata[STATUS_DONE_BIT] = done_sticky_q;
                prdata[STATUS_ERR_BIT]  = err_sticky_q;
            end
            REG_LEN:       prdata = len_q;
            REG_COEF_ADDR: prdata = 32'(coef_addr_q);
            REG_CHECKSUM:  prdata = checksum_rd;
            default:       prdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dac_filter_loader.sv
// Directed bench for dac_filter_loader; a tap scoreboard checks every cfg_ce beat in order.
module tb_dac_filter_loader;

    localparam int NUM_TAPS   = 64;
    localparam int COEF_WIDTH = 25;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  penable = 1'b0;
    logic                  psel = 1'b0;
    logic [31:0]           paddr = '0;
    logic                  pwrite = 1'b0;
    logic [31:0]           pwdata = '0;
    logic [31:0]           prdata;
    logic [COEF_WIDTH-1:0] cfg_din;
    logic                  cfg_ce;
    logic                  mute;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;
    int ce_seen = 0;
    int done_seen = 0;
    logic [COEF_WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    dac_filter_loader #(
        .NUM_TAPS      (NUM_TAPS),
        .COEF_WIDTH    (COEF_WIDTH),
        .DRAIN_CYCLES  (16),
        .SETTLE_CYCLES (64)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .penable (penable),
        .psel    (psel),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .cfg_din (cfg_din),
        .cfg_ce  (cfg_ce),
        .mute    (mute),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each cfg_ce beat must match the next queued tap.
    always @(negedge clk) begin
        logic [COEF_WIDTH-1:0] e;
        if (cfg_ce) begin
            ce_seen++;
            if (exp_q.size() == 0) begin
                check("tap_cfg_ce_unexpected", 32'(cfg_ce), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("TAP din=0x%07h expected=0x%07h", cfg_din, e);
                check("tap", 32'(cfg_din), 32'(e));
            end
        end
        if (done) begin
            done_seen++;
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = {24'h0, a}; pwdata = d;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("WR addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'h0, a};
        @(negedge clk);
        d = prdata;
        psel = 1'b0;
        $display("RD addr=0x%02h data=0x%08h", a, d);
        check(tag, d, exp);
    endtask

    // Cycle 1 is the first cycle after the START write; runs until done or the budget expires.
    task automatic run_to_done(input int max_cyc, output int first_ce, output int n_ce,
                               output int done_at, output logic busy_before, output logic busy_at_done);
        first_ce = -1; n_ce = 0; done_at = -1; busy_before = 1'b0; busy_at_done = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (cfg_ce) begin
                n_ce++;
                if (first_ce < 0) first_ce = c;
            end
            if (done) begin
                done_at = c;
                busy_at_done = busy | mute;
                break;
            end
            busy_before = busy & mute;
        end
    endtask

    task automatic wait_first_ce(input int max_cyc, output logic found);
        found = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (cfg_ce) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_taps_1_to_8();
        for (int t = 8; t >= 1; t--) exp_q.push_back(COEF_WIDTH'(t));
    endtask

    initial begin
        int first_ce, n_ce, done_at, ce0, dn0;
        logic busy_b, busy_d, found, active;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ce", 32'(cfg_ce), 32'd0);
        check("rst_cfg_din", 32'(cfg_din), 32'd0);
        check("rst_mute", 32'(mute), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        read_check("rst_status", 8'h04, 32'd0);
        read_check("rst_len", 8'h08, 32'd64);
        read_check("rst_coef_addr", 8'h0C, 32'd0);

        // Basic reload: taps 1..8, expect 8,7,...,1
        bus_write(8'h0C, 32'd0);
        for (int i = 1; i <= 8; i++) bus_write(8'h10, 32'(i));
        read_check("coef_addr_after_8", 8'h0C, 32'd8);
        bus_write(8'h08, 32'd8);
        push_taps_1_to_8();
        bus_write(8'h00, 32'd1);
        run_to_done(200, first_ce, n_ce, done_at, busy_b, busy_d);
        check("load_first_ce", 32'(first_ce), 32'd17);
        check("load_ce_count", 32'(n_ce), 32'd8);
        check("load_done_at", 32'(done_at), 32'd89);
        check("load_busy_before_done", 32'(busy_b), 32'd1);
        check("load_busy_at_done", 32'(busy_d), 32'd0);
        check("load_sb_empty", 32'(exp_q.size()), 32'd0);
        read_check("load_status", 8'h04, 32'h2);
        bus_write(8'h04, 32'h2);
        read_check("load_status_clr", 8'h04, 32'h0);

        // Illegal lengths
        bus_write(8'h08, 32'd0);
        bus_write(8'h00, 32'd1);
        active = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy | mute | cfg_ce) active = 1'b1;
        end
        check("len0_idle", 32'(active), 32'd0);
        read_check("len0_status", 8'h04, 32'h4);
        bus_write(8'h04, 32'h4);
        read_check("len0_status_clr", 8'h04, 32'h0);
        bus_write(8'h08, 32'd65);
        bus_write(8'h00, 32'd1);
        read_check("len65_status", 8'h04, 32'h4);
        bus_write(8'h04, 32'h4);

        // ABORT during the 3rd STREAM cycle
        bus_write(8'h08, 32'd8);
        push_taps_1_to_8();
        ce0 = ce_seen;
        dn0 = done_seen;
        bus_write(8'h00, 32'd1);
        wait_first_ce(40, found);
        check("abort_ce_found", 32'(found), 32'd1);
        @(posedge clk);
        bus_write(8'h00, 32'h2);
        @(negedge clk);
        check("abort_mute", 32'(mute), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cfg_ce", 32'(cfg_ce), 32'd0);
        check("abort_ce_count", 32'(ce_seen - ce0), 32'd2);
        check("abort_sb_left", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
        read_check("abort_status", 8'h04, 32'h4);
        repeat (100) @(posedge clk);
        check("abort_no_done", 32'(done_seen - dn0), 32'd0);
        bus_write(8'h04, 32'h6);

        // COEF_DATA write during SETTLE must be dropped
        bus_write(8'h0C, 32'd0);
        push_taps_1_to_8();
        bus_write(8'h00, 32'd1);
        repeat (30) @(posedge clk);
        bus_write(8'h10, 32'h000A_BCDE);
        run_to_done(200, first_ce, n_ce, done_at, busy_b, busy_d);
        check("settle_done_at", 32'(done_at), 32'd57);
        read_check("settle_status", 8'h04, 32'h6);
        read_check("settle_coef_addr", 8'h0C, 32'd0);
        bus_write(8'h04, 32'h6);
        push_taps_1_to_8();
        bus_write(8'h00, 32'd1);
        run_to_done(200, first_ce, n_ce, done_at, busy_b, busy_d);
        check("reload_ce_count", 32'(n_ce), 32'd8);
        check("reload_done_at", 32'(done_at), 32'd89);
        check("reload_sb_empty", 32'(exp_q.size()), 32'd0);
        bus_write(8'h04, 32'h2);

        // COEF_ADDR wrap
        bus_write(8'h0C, 32'(NUM_TAPS - 1));
        bus_write(8'h10, 32'h11);
        bus_write(8'h10, 32'h22);
        read_check("wrap_coef_addr", 8'h0C, 32'd1);
        bus_write(8'h08, 32'd1);
        exp_q.push_back(COEF_WIDTH'(32'h22));
        bus_write(8'h00, 32'd1);
        run_to_done(200, first_ce, n_ce, done_at, busy_b, busy_d);
        check("wrap_ce_count", 32'(n_ce), 32'd1);
        check("wrap_done_at", 32'(done_at), 32'd82);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
        bus_write(8'h04, 32'h2);

        // Reset in the middle of STREAM
        bus_write(8'h08, 32'd8);
        for (int t = 8; t >= 2; t--) exp_q.push_back(COEF_WIDTH'(t));
        exp_q.push_back(COEF_WIDTH'(32'h22));
        bus_write(8'h00, 32'd1);
        wait_first_ce(40, found);
        check("rstmid_ce_found", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_mute", 32'(mute), 32'd0);
        check("rstmid_cfg_ce", 32'(cfg_ce), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_sb_left", 32'(exp_q.size()), 32'd7);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        read_check("rstmid_status", 8'h04, 32'h0);
        read_check("rstmid_len", 8'h08, 32'd64);
        read_check("rstmid_coef_addr", 8'h0C, 32'd0);

`ifdef DAC_FILTER_LOADER_CHECKSUM_EN
        bus_write(8'h0C, 32'd0);
        bus_write(8'h10, 32'h01FF_FFFF);
        bus_write(8'h10, 32'd2);
        bus_write(8'h10, 32'd3);
        bus_write(8'h08, 32'd3);
        exp_q.push_back(COEF_WIDTH'(3));
        exp_q.push_back(COEF_WIDTH'(2));
        exp_q.push_back(COEF_WIDTH'(32'h01FF_FFFF));
        bus_write(8'h00, 32'd1);
        run_to_done(200, first_ce, n_ce, done_at, busy_b, busy_d);
        check("cks_ce_count", 32'(n_ce), 32'd3);
        read_check("checksum", 8'h14, 32'd4);
`else
        read_check("checksum_off", 8'h14, 32'd0);
`endif
        read_check("unmapped", 8'h20, 32'd0);
        check("sb_final", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
